// File: rtl/arb_pkg.sv
// ----------------------------------------------------------------------------
// arb_pkg
// Shared types and constants for the round-robin bus arbiter.
//   arb_state_t   : arbiter FSM states (idle, grant held, one dead turn cycle)
//   BUS_ADDR_W    : shared-bus address width (bit 8 selects GPIO space)
//   BUS_DATA_W    : shared-bus data width
//   GPIO_FLAG_BIT : address bit that routes an access to GPIO
//   wrap_inc      : (idx + 1) mod n, used to advance the round-robin pointer
// ----------------------------------------------------------------------------
package arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_GRANT = 2'd1,
        ARB_TURN  = 2'd2
    } arb_state_t;

    localparam int BUS_ADDR_W    = 9;
    localparam int BUS_DATA_W    = 8;
    localparam int GPIO_FLAG_BIT = 8;

    function automatic int wrap_inc(input int idx, input int n);
        int r;
        r = idx + 1;
        if (r >= n) begin
            r = r - n;
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// ----------------------------------------------------------------------------
// rr_pick
// Purely combinational round-robin selector: finds the first set request bit
// at or after ptr, wrapping modulo NUM_REQ.
//   req      in  NUM_REQ  request vector
//   ptr      in  OWNER_W  index with top priority
//   pick     out NUM_REQ  one-hot selection (all-zero when no request)
//   pick_idx out OWNER_W  index of the selected request (0 when none)
//   any_req  out 1        at least one request bit set
// ----------------------------------------------------------------------------
module rr_pick #(
    parameter int NUM_REQ = 2,
    parameter int OWNER_W = 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [OWNER_W-1:0] ptr,
    output logic [NUM_REQ-1:0] pick,
    output logic [OWNER_W-1:0] pick_idx,
    output logic               any_req
);

    int   idx;
    logic found;

    always_comb begin
        pick     = '0;
        pick_idx = '0;
        any_req  = |req;
        found    = 1'b0;
        idx      = 0;
        // Scan NUM_REQ positions starting at ptr; the first hit wins.
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = int'(ptr) + i;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!found && req[idx]) begin
                found     = 1'b1;
                pick      = '0;
                pick[idx] = 1'b1;
                pick_idx  = OWNER_W'(idx);
            end
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// ----------------------------------------------------------------------------
// bus_arbiter
// Round-robin arbiter for the shared 8-bit memory/GPIO bus. One master owns
// the bus while it keeps requesting; a single dead cycle (ARB_TURN) separates
// consecutive owners. The owner's rw/address/data are muxed onto the bus and
// read data is broadcast to every master.
//
// Optional feature, macro ARB_TIMEOUT_EN: a tenure limit of MAX_HOLD cycles,
// enforced only when another master is waiting.
//
// Ports:
//   clk        in  1            rising-edge clock
//   reset      in  1            asynchronous, active-low
//   req        in  NUM_REQ      grant_request per master
//   gnt        out NUM_REQ      grant_given per master (one-hot or zero)
//   m_rw       in  NUM_REQ      per-master rw (1 = write)
//   m_addr     in  9*NUM_REQ    per-master address (bit 8 = GPIO)
//   m_wdata    in  8*NUM_REQ    per-master write data
//   m_rdata    out 8            broadcast read data
//   bus_rw     out 1            shared-bus rw
//   bus_addr   out 9            shared-bus address
//   bus_wdata  out 8            shared-bus write data
//   bus_rdata  in  8            read data from memory/GPIO
//   bus_valid  out 1            some grant is active
//   owner      out OWNER_W      current owner index (0 when idle)
// ----------------------------------------------------------------------------
module bus_arbiter
    import arb_pkg::*;
#(
    parameter  int NUM_REQ  = 2,
    parameter  int MAX_HOLD = 16,
    localparam int OWNER_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [NUM_REQ-1:0]               req,
    output logic [NUM_REQ-1:0]               gnt,
    input  logic [NUM_REQ-1:0]               m_rw,
    input  logic [BUS_ADDR_W*NUM_REQ-1:0]    m_addr,
    input  logic [BUS_DATA_W*NUM_REQ-1:0]    m_wdata,
    output logic [BUS_DATA_W-1:0]            m_rdata,
    output logic                             bus_rw,
    output logic [BUS_ADDR_W-1:0]            bus_addr,
    output logic [BUS_DATA_W-1:0]            bus_wdata,
    input  logic [BUS_DATA_W-1:0]            bus_rdata,
    output logic                             bus_valid,
    output logic [OWNER_W-1:0]               owner
);

    if (MAX_HOLD < 2) begin : g_hold_check
        $error("bus_arbiter: MAX_HOLD must be at least 2");
    end

    arb_state_t           state_reg, state_next;
    logic [OWNER_W-1:0]   ptr_reg, ptr_next;
    logic [OWNER_W-1:0]   owner_reg, owner_next;
    logic [NUM_REQ-1:0]   gnt_reg, gnt_next;

    logic [NUM_REQ-1:0]   pick;
    logic [OWNER_W-1:0]   pick_idx;
    logic                 any_req;
    logic [OWNER_W-1:0]   ptr_after_owner;
    logic                 hold_expired;

    // Per-master address/data slices as arrays for a simple indexed mux.
    logic [BUS_ADDR_W-1:0] addr_arr  [NUM_REQ];
    logic [BUS_DATA_W-1:0] wdata_arr [NUM_REQ];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_slice
            assign addr_arr[gi]  = m_addr[gi*BUS_ADDR_W +: BUS_ADDR_W];
            assign wdata_arr[gi] = m_wdata[gi*BUS_DATA_W +: BUS_DATA_W];
        end
    endgenerate

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .OWNER_W (OWNER_W)
    ) u_rr_pick (
        .req      (req),
        .ptr      (ptr_reg),
        .pick     (pick),
        .pick_idx (pick_idx),
        .any_req  (any_req)
    );

    // With NUM_REQ = 1 this wraps to 0, so ptr stays fixed.
    assign ptr_after_owner = OWNER_W'(wrap_inc(int'(owner_reg), NUM_REQ));

`ifdef ARB_TIMEOUT_EN
    localparam int HOLD_W = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

    logic [HOLD_W-1:0] hold_cnt_reg, hold_cnt_next;

    // Pre-empt only when the tenure limit is reached and someone else waits.
    assign hold_expired = (hold_cnt_reg == HOLD_LAST) && ((req & ~gnt_reg) != '0);
`else
    assign hold_expired = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg    <= ARB_IDLE;
            ptr_reg      <= '0;
            owner_reg    <= '0;
            gnt_reg      <= '0;
`ifdef ARB_TIMEOUT_EN
            hold_cnt_reg <= '0;
`endif
        end else begin
            state_reg    <= state_next;
            ptr_reg      <= ptr_next;
            owner_reg    <= owner_next;
            gnt_reg      <= gnt_next;
`ifdef ARB_TIMEOUT_EN
            hold_cnt_reg <= hold_cnt_next;
`endif
        end
    end

    always_comb begin
        state_next    = state_reg;
        ptr_next      = ptr_reg;
        owner_next    = owner_reg;
        gnt_next      = gnt_reg;
`ifdef ARB_TIMEOUT_EN
        hold_cnt_next = hold_cnt_reg;
`endif
        case (state_reg)
            ARB_IDLE, ARB_TURN: begin
                if (any_req) begin
                    gnt_next      = pick;
                    owner_next    = pick_idx;
                    state_next    = ARB_GRANT;
`ifdef ARB_TIMEOUT_EN
                    hold_cnt_next = '0;
`endif
                end else begin
                    gnt_next   = '0;
                    owner_next = '0;
                    state_next = ARB_IDLE;
                end
            end
            ARB_GRANT: begin
                if (!req[owner_reg] || hold_expired) begin
                    gnt_next   = '0;
                    owner_next = '0;
                    ptr_next   = ptr_after_owner;
                    state_next = ARB_TURN;
                end
`ifdef ARB_TIMEOUT_EN
                else if (hold_cnt_reg != HOLD_LAST) begin
                    hold_cnt_next = hold_cnt_reg + 1'b1;
                end
`endif
            end
            default: begin
                gnt_next   = '0;
                owner_next = '0;
                state_next = ARB_IDLE;
            end
        endcase
    end

    // Bus outputs derive from registered state only, so an asynchronous
    // reset clears them immediately.
    assign gnt       = gnt_reg;
    assign owner     = owner_reg;
    assign bus_valid = |gnt_reg;
    assign bus_rw    = bus_valid ? m_rw[owner_reg]      : 1'b0;
    assign bus_addr  = bus_valid ? addr_arr[owner_reg]  : '0;
    assign bus_wdata = bus_valid ? wdata_arr[owner_reg] : '0;
    assign m_rdata   = bus_rdata;

endmodule

// File: tb/tb_bus_arbiter.sv
// ----------------------------------------------------------------------------
// tb_bus_arbiter
// Directed self-checking bench for bus_arbiter (NUM_REQ = 2, MAX_HOLD = 4).
// Expectations for the tenure limit follow ARB_TIMEOUT_EN.
// ----------------------------------------------------------------------------
module tb_bus_arbiter;

    logic        clk;
    logic        rst_n;
    logic [1:0]  req;
    logic [1:0]  gnt;
    logic [1:0]  m_rw;
    logic [17:0] m_addr;
    logic [15:0] m_wdata;
    logic [7:0]  m_rdata;
    logic        bus_rw;
    logic [8:0]  bus_addr;
    logic [7:0]  bus_wdata;
    logic [7:0]  bus_rdata;
    logic        bus_valid;
    logic [0:0]  owner;

    int n_checks;
    int n_fail;

    bus_arbiter #(
        .NUM_REQ  (2),
        .MAX_HOLD (4)
    ) dut (
        .clk       (clk),
        .reset     (rst_n),
        .req       (req),
        .gnt       (gnt),
        .m_rw      (m_rw),
        .m_addr    (m_addr),
        .m_wdata   (m_wdata),
        .m_rdata   (m_rdata),
        .bus_rw    (bus_rw),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata),
        .bus_rdata (bus_rdata),
        .bus_valid (bus_valid),
        .owner     (owner)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_val);
        n_checks++;
        if (obs !== exp_val) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp_val, $time);
        end else begin
            $display("ok   %s: 0x%0h (t=%0t)", tag, obs, $time);
        end
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int o;
        int waited;
        n_checks  = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        req       = 2'b11;
        m_rw      = 2'b10;
        m_addr    = {9'h100, 9'h1A5};
        m_wdata   = {8'h5C, 8'h33};
        bus_rdata = 8'hC3;

        // Reset held with both masters requesting.
        step();
        step();
        check("reset_gnt",       32'(gnt), 32'h0);
        check("reset_valid",     32'(bus_valid), 32'h0);
        check("reset_owner",     32'(owner), 32'h0);
        check("reset_bus_addr",  32'(bus_addr), 32'h0);
        check("reset_bus_rw",    32'(bus_rw), 32'h0);

        req   = 2'b00;
        rst_n = 1'b1;
        step();
        check("idle_gnt", 32'(gnt), 32'h0);

        // Single request from master 0.
        req = 2'b01;
        step();
        check("single_gnt",       32'(gnt), 32'h1);
        check("single_owner",     32'(owner), 32'h0);
        check("single_bus_addr",  32'(bus_addr), 32'h1A5);
        check("single_bus_wdata", 32'(bus_wdata), 32'h33);
        check("single_bus_rw",    32'(bus_rw), 32'h0);
        check("single_valid",     32'(bus_valid), 32'h1);
        check("rdata_bcast",      32'(m_rdata), 32'hC3);

        // Master 1 raises while master 0 holds: ignored.
        req = 2'b11;
        step();
        check("hold_gnt", 32'(gnt), 32'h1);

        // Master 0 drops: one dead cycle, then master 1.
        req = 2'b10;
        step();
        check("turn_gnt",       32'(gnt), 32'h0);
        check("turn_valid",     32'(bus_valid), 32'h0);
        check("turn_bus_rw",    32'(bus_rw), 32'h0);
        check("turn_bus_addr",  32'(bus_addr), 32'h0);
        check("turn_bus_wdata", 32'(bus_wdata), 32'h0);
        check("turn_owner",     32'(owner), 32'h0);
        step();
        check("m1_gnt",       32'(gnt), 32'h2);
        check("m1_owner",     32'(owner), 32'h1);
        check("m1_bus_rw",    32'(bus_rw), 32'h1);
        check("m1_bus_addr",  32'(bus_addr), 32'h100);
        check("m1_bus_wdata", 32'(bus_wdata), 32'h5C);

        // Reset mid-tenure: revoked without a clock edge.
        req = 2'b11;
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_gnt",   32'(gnt), 32'h0);
        check("midrst_valid", 32'(bus_valid), 32'h0);
        check("midrst_addr",  32'(bus_addr), 32'h0);
        step();
        rst_n = 1'b1;
        step();
        check("postrst_gnt", 32'(gnt), 32'h1);

        // Fairness: 3-cycle tenures alternate 0,1,0,1.
        o = 0;
        for (int t = 0; t < 4; t++) begin
            for (int c = 0; c < 3; c++) begin
                check($sformatf("fair%0d_c%0d_gnt", t, c), 32'(gnt), 32'(1 << o));
                if (c < 2) step();
            end
            req = 2'b11 & ~2'(1 << o);
            step();
            check($sformatf("fair%0d_turn_gnt", t), 32'(gnt), 32'h0);
            req = 2'b11;
            step();
            o = 1 - o;
        end

        // Tenure limit with master 1 waiting.
        for (int c = 1; c <= 4; c++) begin
            check($sformatf("hold_m0_c%0d", c), 32'(gnt), 32'h1);
            step();
        end
`ifdef ARB_TIMEOUT_EN
        check("timeout_turn_gnt", 32'(gnt), 32'h0);
        step();
        check("timeout_m1_gnt", 32'(gnt), 32'h2);
`else
        for (int c = 5; c <= 8; c++) begin
            check($sformatf("nolimit_m0_c%0d", c), 32'(gnt), 32'h1);
            step();
        end
`endif

        // Only master 0 requests: grant must be kept for 20+ cycles.
        req    = 2'b01;
        waited = 0;
        while (gnt !== 2'b01 && waited < 4) begin
            step();
            waited++;
        end
        check("solo_acquire", 32'(gnt), 32'h1);
        for (int c = 0; c < 22; c++) begin
            step();
            check($sformatf("solo_c%0d", c), 32'(gnt), 32'h1);
        end

        // Withdraw in the cycle the grant appears: one-cycle tenure.
        req = 2'b00;
        step();
        check("solo_rel_gnt", 32'(gnt), 32'h0);
        step();
        check("idle2_gnt", 32'(gnt), 32'h0);
        req = 2'b10;
        step();
        check("blip_gnt", 32'(gnt), 32'h2);
        req = 2'b00;
        step();
        check("blip_rel_gnt", 32'(gnt), 32'h0);
        step();
        check("blip_idle_gnt", 32'(gnt), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
